// File: rtl/swarm_pkg.sv
// Shared swarm definitions: FSM state encoding, field widths and default
// timing / geometry constants used by the stepper, aliens and renderer.
package swarm_pkg;

  typedef enum logic [1:0] {
    MARCH_R = 2'd0,
    MARCH_L = 2'd1,
    DESCEND = 2'd2,
    LANDED  = 2'd3
  } swarm_state_e;

  localparam int unsigned ADD_X_W = 3;
  localparam int unsigned Y_W     = 7;
  localparam int unsigned ALIVE_W = 6;
  localparam int unsigned CNT_W   = 8;

  localparam logic [ADD_X_W-1:0] ADD_X_MAX = 3'd7;

  localparam int unsigned SLOW_PERIOD_DEF = 8;
  localparam int unsigned FAST_PERIOD_DEF = 2;
  localparam int unsigned FAST_THRESH_DEF = 4;
  localparam int unsigned Y_STEP_DEF      = 4;
  localparam int unsigned Y_LIMIT_DEF     = 96;

endpackage

// File: rtl/tick_divider.sv
// Frame-tick divider with an alive-count dependent period.
// Ports: clk, reset_n (sync, active-low), tick_en (qualified frame tick),
//        alive_count (aliens remaining), step_c (combinational step strobe).
module tick_divider
  import swarm_pkg::*;
#(
  parameter int unsigned SLOW_PERIOD = SLOW_PERIOD_DEF,
  parameter int unsigned FAST_PERIOD = FAST_PERIOD_DEF,
  parameter int unsigned FAST_THRESH = FAST_THRESH_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick_en,
  input  logic [ALIVE_W-1:0] alive_count,
  output logic               step_c
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] period_m1;

  // Period is re-evaluated on every tick; a count already past a shorter
  // period steps immediately.
  always_comb begin
    period_m1 = (alive_count <= ALIVE_W'(FAST_THRESH)) ? CNT_W'(FAST_PERIOD - 1)
                                                         : CNT_W'(SLOW_PERIOD - 1);
    step_c    = tick_en && (count >= period_m1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (tick_en) begin
      count <= step_c ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/swarm_stepper.sv
// Swarm march controller: steps the alien formation left/right, descends at
// the edges and latches landed once the formation reaches Y_LIMIT.
// Ports: clk, reset_n (sync, active-low), enable (freeze when low),
//        frame_tick (per-frame pulse), alive_count (aliens left),
//        add_x / y_offset (formation offsets), dir (1 = right),
//        step_pulse (one cycle per applied step), landed (sticky).
module swarm_stepper
  import swarm_pkg::*;
#(
  parameter int unsigned SLOW_PERIOD = SLOW_PERIOD_DEF,
  parameter int unsigned FAST_PERIOD = FAST_PERIOD_DEF,
  parameter int unsigned FAST_THRESH = FAST_THRESH_DEF,
  parameter int unsigned Y_STEP      = Y_STEP_DEF,
  parameter int unsigned Y_LIMIT     = Y_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               frame_tick,
  input  logic [ALIVE_W-1:0] alive_count,
  output logic [ADD_X_W-1:0] add_x,
  output logic [Y_W-1:0]     y_offset,
  output logic               dir,
  output logic               step_pulse,
  output logic               landed
);

  swarm_state_e state;
  logic         tick_en;
  logic         step_c;
  logic [7:0]   y_sum;

  // Ticks are discarded while disabled or once landed.
  assign tick_en = enable && frame_tick && !landed;
  // One bit wider than y_offset so the limit compare cannot wrap.
  assign y_sum   = {1'b0, y_offset} + 8'(Y_STEP);

  tick_divider #(
    .SLOW_PERIOD (SLOW_PERIOD),
    .FAST_PERIOD (FAST_PERIOD),
    .FAST_THRESH (FAST_THRESH)
  ) u_tick_divider (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick_en     (tick_en),
    .alive_count (alive_count),
    .step_c      (step_c)
  );

  // March FSM; all outputs registered and updated only on a step.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= MARCH_R;
      add_x      <= '0;
      y_offset   <= '0;
      dir        <= 1'b1;
      step_pulse <= 1'b0;
      landed     <= 1'b0;
    end else begin
      step_pulse <= step_c;
      if (step_c) begin
        case (state)
          MARCH_R: begin
            if (add_x < ADD_X_MAX) add_x <= add_x + ADD_X_W'(1);
            else                   state <= DESCEND;
          end
          MARCH_L: begin
            if (add_x > '0) add_x <= add_x - ADD_X_W'(1);
            else            state <= DESCEND;
          end
          DESCEND: begin
            if (y_sum >= 8'(Y_LIMIT)) begin
              y_offset <= Y_W'(Y_LIMIT);
              landed   <= 1'b1;
              state    <= LANDED;
            end else begin
              y_offset <= y_sum[Y_W-1:0];
              dir      <= !dir;
              state    <= dir ? MARCH_L : MARCH_R;
            end
          end
          default: state <= LANDED;
        endcase
      end
    end
  end

endmodule
